// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, synchronous imem read port and IF/ID bundle.
// A one-entry hold buffer keeps the in-flight word across a stall.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          IMEM_ADDR_W = 14,
   parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   Pause,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   input  logic [31:0]            imem_rdata,
   output logic [31:0]            IF_pc_i,
   output logic [31:0]            IF_pc4_i,
   output logic [31:0]            IF_inst,
   output logic                   IF_valid
);

   typedef enum logic [1:0] {
      BUBBLE = 2'b00,
      ILLEGAL = 2'b01,
      RUN    = 2'b10,
      HOLD   = 2'b11
   } state_e;

   logic [31:0] pc_q, pc_d;
   logic [31:0] resp_pc_q, resp_pc_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic        hold_valid_q, hold_valid_d;
   state_e      state;

   assign state = state_e'({resp_valid_q, hold_valid_q});

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q         <= RESET_PC;
         resp_pc_q    <= 32'h0;
         resp_valid_q <= 1'b0;
         hold_inst_q  <= 32'h0;
         hold_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         resp_pc_q    <= resp_pc_d;
         resp_valid_q <= resp_valid_d;
         hold_inst_q  <= hold_inst_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   always_comb begin
      pc_d         = pc_q;
      resp_pc_d    = resp_pc_q;
      resp_valid_d = resp_valid_q;
      hold_inst_d  = hold_inst_q;
      hold_valid_d = hold_valid_q;
      if (redirect) begin
         pc_d         = redirect_pc & 32'hFFFF_FFFC;
         resp_valid_d = 1'b0;
         hold_valid_d = 1'b0;
      end else if (Pause) begin
         // Capture the word in flight; memory moves on to pc_q next cycle.
         unique case (state)
            RUN: begin
               hold_inst_d  = imem_rdata;
               hold_valid_d = 1'b1;
            end
            default: ;
         endcase
      end else begin
         resp_pc_d    = pc_q;
         resp_valid_d = 1'b1;
         hold_valid_d = 1'b0;
         pc_d         = pc_q + 32'd4;
      end
   end

   assign imem_addr = pc_q[IMEM_ADDR_W+1:2];
   assign IF_pc_i   = resp_pc_q;
   assign IF_pc4_i  = resp_pc_q + 32'd4;
   assign IF_valid  = resp_valid_q;
   assign IF_inst   = !resp_valid_q ? NOP_INST :
                      hold_valid_q  ? hold_inst_q : imem_rdata;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random pause/redirect
// traffic against a stream-level fetch model.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        pause = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] redir_pc = 32'h0;
   logic [13:0] addr1, addr2;
   logic [31:0] rdata1 = 32'h0, rdata2 = 32'h0;
   logic [31:0] pc1, pc41, inst1, pc2, pc42, inst2;
   logic        val1, val2;
   logic        pause2 = 1'b0, redir2 = 1'b0;
   logic [31:0] redir_pc2 = 32'h0;

   int vectors = 0;
   int miscompares = 0;

   // model: presented pc, valid flag and next address to fetch
   logic [31:0] m_pc, m_nxt;
   logic        m_val;

   always #5 clk = ~clk;

   if_fetch_stage u_dut (
      .clk(clk), .rstn(rstn), .Pause(pause), .redirect(redir),
      .redirect_pc(redir_pc), .imem_addr(addr1), .imem_rdata(rdata1),
      .IF_pc_i(pc1), .IF_pc4_i(pc41), .IF_inst(inst1), .IF_valid(val1)
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rstn(rstn), .Pause(pause2), .redirect(redir2),
      .redirect_pc(redir_pc2), .imem_addr(addr2), .imem_rdata(rdata2),
      .IF_pc_i(pc2), .IF_pc4_i(pc42), .IF_inst(inst2), .IF_valid(val2)
   );

   // synchronous instruction memories: word k holds 0x1000_0000 + k
   always @(posedge clk) begin
      rdata1 <= 32'h1000_0000 + {18'h0, addr1};
      rdata2 <= 32'h1000_0000 + {18'h0, addr2};
   end

   function automatic logic [31:0] mem_of(input logic [31:0] a);
      return 32'h1000_0000 + {18'h0, a[15:2]};
   endfunction

   function automatic logic [31:0] exp_inst();
      return m_val ? mem_of(m_pc) : NOP;
   endfunction

   task automatic model_reset();
      m_pc  = 32'h0;
      m_val = 1'b0;
      m_nxt = 32'h0;
   endtask

   // apply one cycle of inputs, advance the model, land on the next negedge
   task automatic drive(input logic p, input logic r, input logic [31:0] t);
      pause = p;
      redir = r;
      redir_pc = t;
      @(posedge clk);
      if (rstn) begin
         if (r) begin
            m_val = 1'b0;
            m_nxt = {t[31:2], 2'b00};
         end else if (!p) begin
            m_pc  = m_nxt;
            m_val = 1'b1;
            m_nxt = m_nxt + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      vectors++;
      if (inst1 !== NOP || val1 !== 1'b0 || pc1 !== 32'h0 || pc41 !== 32'h4) begin
         miscompares++;
         $display("FAIL reset_out: inst=%h valid=%b pc=%h pc4=%h, want %h 0 0 4",
                  inst1, val1, pc1, pc41, NOP);
      end
      vectors++;
      if (addr1 !== 14'h0) begin
         miscompares++;
         $display("FAIL reset_addr: got %h want 0", addr1);
      end
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 32'h0);
         vectors++;
         if (pc1 !== 32'(4*k) || pc41 !== 32'(4*k+4) ||
             inst1 !== 32'h1000_0000 + 32'(k) || val1 !== 1'b1) begin
            miscompares++;
            $display("FAIL first_fetch[%0d]: pc=%h pc4=%h inst=%h v=%b", k,
                     pc1, pc41, inst1, val1);
         end
      end
   endtask

   task automatic test_pause();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 32'h0);
         vectors++;
         if (pc1 !== 32'h8 || inst1 !== 32'h1000_0002 || val1 !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_hold[%0d]: pc=%h inst=%h want 8 10000002",
                     k, pc1, inst1);
         end
      end
      drive(1'b0, 1'b0, 32'h0);
      vectors++;
      if (pc1 !== 32'hC || inst1 !== 32'h1000_0003 || val1 !== 1'b1) begin
         miscompares++;
         $display("FAIL pause_release: pc=%h inst=%h want c 10000003", pc1, inst1);
      end
      drive(1'b0, 1'b0, 32'h0);
      vectors++;
      if (pc1 !== 32'h10 || inst1 !== 32'h1000_0004) begin
         miscompares++;
         $display("FAIL pause_after: pc=%h inst=%h want 10 10000004", pc1, inst1);
      end
   endtask

   task automatic test_redirect();
      drive(1'b0, 1'b1, 32'h0000_0043);
      vectors++;
      if (inst1 !== NOP || val1 !== 1'b0) begin
         miscompares++;
         $display("FAIL redirect_bubble: inst=%h v=%b want %h 0", inst1, val1, NOP);
      end
      drive(1'b0, 1'b0, 32'h0);
      vectors++;
      if (pc1 !== 32'h40 || inst1 !== 32'h1000_0010 || val1 !== 1'b1) begin
         miscompares++;
         $display("FAIL redirect_target: pc=%h inst=%h want 40 10000010", pc1, inst1);
      end
   endtask

   task automatic test_redirect_in_hold();
      drive(1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 32'h0000_0102);
      vectors++;
      if (inst1 !== NOP || val1 !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_redirect: inst=%h v=%b want %h 0", inst1, val1, NOP);
      end
      drive(1'b0, 1'b0, 32'h0);
      vectors++;
      if (pc1 !== 32'h100 || inst1 !== 32'h1000_0040 || val1 !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_redirect_tgt: pc=%h inst=%h want 100 10000040",
                  pc1, inst1);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] wpc [3];
      logic [31:0] wpc4 [3];
      logic [31:0] winst [3];
      wpc   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      wpc4  = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      winst = '{32'h1000_3FFE, 32'h1000_3FFF, 32'h1000_0000};
      rstn = 1'b0;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 32'h0);
         vectors++;
         if (pc2 !== wpc[k] || pc42 !== wpc4[k] || inst2 !== winst[k] ||
             val2 !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap[%0d]: pc=%h pc4=%h inst=%h want %h %h %h", k,
                     pc2, pc42, inst2, wpc[k], wpc4[k], winst[k]);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0);
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (inst1 !== NOP || val1 !== 1'b0 || pc1 !== 32'h0 || pc41 !== 32'h4) begin
         miscompares++;
         $display("FAIL async_reset: inst=%h v=%b pc=%h pc4=%h", inst1, val1,
                  pc1, pc41);
      end
      @(negedge clk);
      rstn = 1'b1;
      drive(1'b0, 1'b0, 32'h0);
      vectors++;
      if (pc1 !== 32'h0 || inst1 !== 32'h1000_0000 || val1 !== 1'b1) begin
         miscompares++;
         $display("FAIL async_restart: pc=%h inst=%h want 0 10000000", pc1, inst1);
      end
   endtask

   task automatic test_random();
      logic        p, r;
      logic [31:0] t;
      for (int n = 0; n < 400; n++) begin
         p = ($urandom_range(99) < 30);
         r = ($urandom_range(99) < 8);
         t = $urandom;
         drive(p, r, t);
         vectors++;
         if (val1 !== m_val || inst1 !== exp_inst() ||
             (m_val && (pc1 !== m_pc || pc41 !== m_pc + 32'd4)) ||
             addr1 !== m_nxt[15:2]) begin
            miscompares++;
            $display("FAIL random[%0d]: pc=%h inst=%h v=%b addr=%h want %h %h %b %h",
                     n, pc1, inst1, val1, addr1, m_pc, exp_inst(), m_val,
                     m_nxt[15:2]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pause();
      test_redirect();
      test_redirect_in_hold();
      test_wrap();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
